// File: rtl/clk_prescaler_if.sv
// Strobe bundle carried from the prescaler to the logic it paces.
// The producer drives en; consumers only sample it.
interface clk_prescaler_if;
  logic en;

  modport master (output en);
  modport slave  (input  en);
endinterface

// File: rtl/clk_prescaler.sv
// Free-running clock-enable generator: one-cycle registered strobe every `ratio` clk50m cycles.
// First strobe follows the ratio-th edge after reset release; no backpressure, strobe is unconditional.
module clk_prescaler #(
  parameter int ratio = 50
) (
  input  logic             clk50m,
  input  logic             rst_n,
  clk_prescaler_if.master  tick
);

  localparam int CW = (ratio > 1) ? $clog2(ratio) : 1;
  localparam logic [CW-1:0] LAST = CW'((ratio >= 1) ? ratio - 1 : 0);

  if (ratio < 1) begin : g_bad_ratio
    $error("clk_prescaler: ratio must be >= 1, got %0d", ratio);
  end

  logic [CW-1:0] cnt;
  logic          en_q;

  // rst_n is active-high here; the name is inherited from the surrounding codebase.
  always_ff @(posedge clk50m) begin
    if (rst_n) begin
      cnt  <= '0;
      en_q <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      en_q <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      en_q <= 1'b0;
    end
  end

  assign tick.en = en_q;

endmodule

// File: tb/tb_clk_prescaler.sv
// Directed bench: four prescalers (50, 100, 1, 2) on one clock and reset, checked each cycle
// against an edges-since-release model queued when the reset level for that edge is driven.
module tb_clk_prescaler;

  logic clk50m = 1'b0;
  logic rst_n  = 1'b1;

  always #10 clk50m = ~clk50m;

  clk_prescaler_if if50 ();
  clk_prescaler_if if100 ();
  clk_prescaler_if if1 ();
  clk_prescaler_if if2 ();

  clk_prescaler #(.ratio(50))  u_p50  (.clk50m(clk50m), .rst_n(rst_n), .tick(if50));
  clk_prescaler #(.ratio(100)) u_p100 (.clk50m(clk50m), .rst_n(rst_n), .tick(if100));
  clk_prescaler #(.ratio(1))   u_p1   (.clk50m(clk50m), .rst_n(rst_n), .tick(if1));
  clk_prescaler #(.ratio(2))   u_p2   (.clk50m(clk50m), .rst_n(rst_n), .tick(if2));

  typedef struct packed {
    logic e50;
    logic e100;
    logic e1;
    logic e2;
  } exp_t;

  exp_t sb[$];

  int vectors   = 0;
  int miscompares = 0;
  int edges     = 0;  // edges sampled with reset inactive since the last reset edge
  bit in_window = 1'b0;
  int win50     = 0;
  int win100    = 0;

  task automatic check(input string tag, input logic obs, input logic exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at edge %0d", tag, obs, exp_v, edges);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    vectors++;
    assert (obs == exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic strobe_at(input int e, input int r);
    return (e > 0) && (e % r == 0);
  endfunction

  // Drive reset for one edge, queue the expected strobes, then compare after the edge.
  task automatic step(input logic r);
    exp_t x;
    @(negedge clk50m);
    rst_n = r;
    edges = r ? 0 : edges + 1;
    x.e50  = strobe_at(edges, 50);
    x.e100 = strobe_at(edges, 100);
    x.e1   = strobe_at(edges, 1);
    x.e2   = strobe_at(edges, 2);
    sb.push_back(x);
    @(posedge clk50m);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      x = sb.pop_front();
      check("en_r50",  if50.en,  x.e50);
      check("en_r100", if100.en, x.e100);
      check("en_r1",   if1.en,   x.e1);
      check("en_r2",   if2.en,   x.e2);
      if (if100.en === 1'b1) check("r100_aligned_r50", if50.en, 1'b1);
    end
    if (in_window) begin
      if (if50.en === 1'b1)  win50++;
      if (if100.en === 1'b1) win100++;
    end
  endtask

  initial begin
    int first_hit;

    // Power-up reset, roughly 90 ns.
    repeat (4) step(1'b1);

    // 10 us window: 500 edges after release.
    in_window = 1'b1;
    repeat (500) step(1'b0);
    in_window = 1'b0;
    check_int("pulses_10us_r50",  win50,  10);
    check_int("pulses_10us_r100", win100, 5);

    // Move to cycle 30 of a ratio-50 count, then reset for 3 cycles.
    repeat (30) step(1'b0);
    repeat (3) step(1'b1);
    first_hit = 0;
    for (int i = 1; i <= 120; i++) begin
      step(1'b0);
      if (first_hit == 0 && if50.en === 1'b1) first_hit = i;
    end
    check_int("relaunch_latency_r50", first_hit, 50);

    // Reach the strobe after edge 150, then assert reset on the next edge.
    repeat (30) step(1'b0);
    check("strobe_before_reset", if50.en, 1'b1);
    step(1'b1);
    check("reset_kills_strobe", if50.en, 1'b0);
    repeat (2) step(1'b1);
    first_hit = 0;
    for (int i = 1; i <= 60; i++) begin
      step(1'b0);
      if (first_hit == 0 && if50.en === 1'b1) first_hit = i;
    end
    check_int("restart_after_strobe_reset", first_hit, 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
